// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the seven-segment scan driver.
//   seg7_t         : segment vector, bit6 = a .. bit0 = g, active-low
//   SEG7_BLANK     : all segments off
//   BCD_BLANK      : digit code that decodes to all segments off
//   DIGIT_PATTERNS : segment patterns for codes 0..9
// ----------------------------------------------------------------------------
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t      SEG7_BLANK = 7'b1111111;
  localparam logic [3:0] BCD_BLANK  = 4'hF;

  // Index 0 is the leftmost entry.
  localparam seg7_t DIGIT_PATTERNS [10] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

endpackage : seg7_pkg

// File: rtl/bcd_to_seg7.sv
// ----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational decoder from a 4-bit digit code to active-low segments.
// Codes 10..15 decode to all segments off.
// Ports:
//   code : in  4-bit digit code
//   seg  : out active-low segments (bit6 = a .. bit0 = g)
// ----------------------------------------------------------------------------
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output seg7_t      seg
);

  // NOTE: combinational outputs get a default before any conditional
  // assignment so no path leaves them unassigned (which would infer a latch).
  always_comb begin
    seg = SEG7_BLANK;
    if (code < 4'd10) seg = DIGIT_PATTERNS[code];
  end

endmodule : bcd_to_seg7

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits
// with active-low anodes and cathodes. Inputs are captured once per scan
// frame into shadow registers, so a frame never mixes old and new values.
// Each digit slot starts with BLANK_CYCLES of all anodes off to avoid ghosting.
//
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN
//   defined   : leading zero digits (above digit 0) are blanked at capture
//   undefined : digits shown exactly as captured
//
// Ports:
//   clk        : in  system clock
//   reset      : in  synchronous, active-high reset
//   bcd_in     : in  digit i on [4i+3:4i], digit 0 rightmost
//   dp_in      : in  decimal point per digit, active-high
//   digit_en   : in  1 = digit displayed, 0 = dark
//   anode      : out active-low digit select, anode[i] drives digit i
//   cathode    : out active-low segments, bit6 = a .. bit0 = g
//   dp_n       : out active-low decimal point
//   frame_done : out one-cycle pulse after the last digit slot ends
// ----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   anode,
  output seg7_t                   cathode,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             prime;

  // Per-frame shadow copies of the inputs
  logic [4*NUM_DIGITS-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_en;

  logic tick;
  logic last_slot;
  logic snap;

  assign tick      = (cnt == CNT_LAST);
  assign last_slot = (idx == IDX_LAST);
  // A tick at the frame boundary coinciding with prime still yields one capture.
  assign snap      = prime || (tick && last_slot);

  // Digit codes as they will be stored at the next capture.
  logic [4*NUM_DIGITS-1:0] snap_bcd;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down; a zero stays blank until an
  // enabled non-zero digit has been seen. Digit 0 is always shown.
  logic zeros_above;

  always_comb begin
    snap_bcd    = bcd_in;
    zeros_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (bcd_in[4*i +: 4] == 4'd0) begin
        if (zeros_above) snap_bcd[4*i +: 4] = BCD_BLANK;
      end else if (digit_en[i]) begin
        zeros_above = 1'b0;
      end
    end
  end
`else
  assign snap_bcd = bcd_in;
`endif

  // Current digit selected from the shadow copy.
  logic [3:0] cur_code;
  logic       cur_en;
  logic       cur_dp;
  seg7_t      cur_seg;

  assign cur_code = shadow_bcd[{idx, 2'b00} +: 4];
  assign cur_en   = shadow_en[idx];
  assign cur_dp   = shadow_dp[idx];

  bcd_to_seg7 u_decode (
    .code (cur_code),
    .seg  (cur_seg)
  );

  // Next anode pattern: at most one low bit, none during the blanking gap.
  logic [NUM_DIGITS-1:0] anode_nxt;

  always_comb begin
    anode_nxt = '1;
    if ((cnt >= BLANK_END) && cur_en) anode_nxt[idx] = 1'b0;
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      prime      <= 1'b1;
      // NOTE: the shadow registers are reset explicitly because the display
      // must stay dark until the first capture after reset.
      shadow_bcd <= {NUM_DIGITS{BCD_BLANK}};
      shadow_dp  <= '0;
      shadow_en  <= '0;
      anode      <= '1;
      cathode    <= SEG7_BLANK;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      prime <= 1'b0;

      if (tick) idx <= last_slot ? '0 : idx + 1'b1;

      if (snap) begin
        shadow_bcd <= snap_bcd;
        shadow_dp  <= dp_in;
        shadow_en  <= digit_en;
      end

      frame_done <= tick && last_slot;

      // Outputs reflect the cnt/idx/shadow of this cycle, one cycle later.
      anode   <= anode_nxt;
      cathode <= cur_en ? cur_seg : SEG7_BLANK;
      dp_n    <= ~(cur_dp & cur_en);
    end
  end

endmodule : seg7_scan_driver
